// File: rtl/match_collector_if.sv
// Signal bundle between the literal-scan collector, its requester, the
// table/comparator path and the hit consumer.
interface match_collector_if #(
    parameter int COLS_PER_ROW = 4,
    parameter int LIT_WIDTH    = 6,
    parameter int NUM_ROWS     = 64
);
    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int COL_W = (COLS_PER_ROW > 1) ? $clog2(COLS_PER_ROW) : 1;
    localparam int CNT_W = ROW_W + COL_W + 1;

    logic                    start;
    logic [LIT_WIDTH-1:0]    target_in;
    logic [ROW_W:0]          num_rows_in;
    logic                    busy;
    logic                    done;
    logic [ROW_W-1:0]        row_addr;
    logic [LIT_WIDTH-1:0]    target_literal;
    logic [COLS_PER_ROW-1:0] match_mask;
    // Hit stream: a hit transfers on a clock edge where hit_valid && hit_ready;
    // while hit_valid && !hit_ready, hit_row/hit_col hold and valid stays high.
    logic                    hit_valid;
    logic                    hit_ready;
    logic [ROW_W-1:0]        hit_row;
    logic [COL_W-1:0]        hit_col;
    logic [CNT_W-1:0]        hit_count;

    modport master (
        output start, target_in, num_rows_in, match_mask, hit_ready,
        input  busy, done, row_addr, target_literal, hit_valid, hit_row,
               hit_col, hit_count
    );

    modport slave (
        input  start, target_in, num_rows_in, match_mask, hit_ready,
        output busy, done, row_addr, target_literal, hit_valid, hit_row,
               hit_col, hit_count
    );
endinterface

// File: rtl/match_collector.sv
// Scans the clause-literal table row by row for one target literal and
// serializes every matching (row, col) as a hit on a valid/ready stream.
module match_collector #(
    parameter int COLS_PER_ROW = 4,
    parameter int LIT_WIDTH    = 6,
    parameter int NUM_ROWS     = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    match_collector_if.slave     bus_io,
    output logic [2:0]           dbg_state_o
);
    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int COL_W = (COLS_PER_ROW > 1) ? $clog2(COLS_PER_ROW) : 1;
    localparam int CNT_W = ROW_W + COL_W + 1;
    localparam logic [ROW_W:0] MAX_ROWS = (ROW_W+1)'(NUM_ROWS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EVAL  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [LIT_WIDTH-1:0]    target_q, target_d;
    logic [ROW_W:0]          rows_q, rows_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COLS_PER_ROW-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic                    last_row;
    logic [COLS_PER_ROW-1:0] low_bit;
    logic [COL_W-1:0]        low_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            rows_q   <= '0;
            row_q    <= '0;
            pend_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            rows_q   <= rows_d;
            row_q    <= row_d;
            pend_q   <= pend_d;
            count_q  <= count_d;
        end
    end

    assign last_row = ({1'b0, row_q} == (rows_q - (ROW_W+1)'(1)));
    // Two's-complement trick isolates the lowest pending match.
    assign low_bit  = pend_q & (~pend_q + COLS_PER_ROW'(1));

    always_comb begin
        low_col = '0;
        for (int i = COLS_PER_ROW - 1; i >= 0; i--) begin
            if (pend_q[i]) low_col = COL_W'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        rows_d   = rows_q;
        row_d    = row_q;
        pend_d   = pend_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if (bus_io.start) begin
                    target_d = bus_io.target_in;
                    rows_d   = (bus_io.num_rows_in > MAX_ROWS) ? MAX_ROWS
                                                               : bus_io.num_rows_in;
                    row_d    = '0;
                    pend_d   = '0;
                    count_d  = '0;
                    state_d  = (rows_d == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_EVAL;
            S_EVAL: begin
                pend_d = bus_io.match_mask;
                if (bus_io.match_mask != '0) begin
                    state_d = S_EMIT;
                end else if (last_row) begin
                    state_d = S_DONE;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_EMIT: begin
                if (bus_io.hit_ready) begin
                    pend_d  = pend_q & ~low_bit;
                    count_d = count_q + CNT_W'(1);
                    if (pend_d == '0) begin
                        if (last_row) begin
                            state_d = S_DONE;
                        end else begin
                            row_d   = row_q + ROW_W'(1);
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus_io.busy           = (state_q == S_FETCH) || (state_q == S_EVAL) ||
                                   (state_q == S_EMIT);
    assign bus_io.done           = (state_q == S_DONE);
    assign bus_io.row_addr       = row_q;
    assign bus_io.target_literal = target_q;
    assign bus_io.hit_valid      = (state_q == S_EMIT);
    assign bus_io.hit_row        = row_q;
    assign bus_io.hit_col        = low_col;
    assign bus_io.hit_count      = count_q;
    assign dbg_state_o           = state_q;
endmodule

// File: tb/tb_match_collector.sv
// Bench for match_collector: table + comparator model, reference hit list
// built from the scan rules, and a monitor that consumes the hit stream.
module tb_match_collector;
  localparam int COLS   = 4;
  localparam int LITW   = 6;
  localparam int NROWS  = 64;
  localparam int ROW_W  = 6;
  localparam int COL_W  = 2;
  localparam int HIT_W  = ROW_W + COL_W;
  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  match_collector_if #(.COLS_PER_ROW(COLS), .LIT_WIDTH(LITW), .NUM_ROWS(NROWS)) bus ();
  logic [2:0] dbg_state;

  match_collector #(.COLS_PER_ROW(COLS), .LIT_WIDTH(LITW), .NUM_ROWS(NROWS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_io(bus),
    .dbg_state_o(dbg_state)
  );

  // table with 1-cycle synchronous read, comparator on the read row
  logic [LITW-1:0] tbl [NROWS][COLS];
  logic [ROW_W-1:0] rd_row;
  logic [COLS-1:0] mask;
  always @(posedge clk) rd_row <= bus.row_addr;
  always_comb begin
    mask = '0;
    for (int c = 0; c < COLS; c++)
      mask[c] = (bus.target_literal != '0) && (tbl[rd_row][c] == bus.target_literal);
  end
  assign bus.match_mask = mask;

  int n_vec = 0;
  int n_err = 0;
  logic [HIT_W-1:0] exp_q[$];
  int done_cnt = 0;
  int max_row = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: held low

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // hit_ready driver
  initial begin
    bus.hit_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.hit_ready = 1'b1;
        1: bus.hit_ready = 1'($urandom_range(0, 1));
        default: bus.hit_ready = 1'b0;
      endcase
    end
  end

  // monitor: pops the scoreboard on every handshake, checks stall stability
  logic stalled = 1'b0;
  logic [HIT_W-1:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (bus.done) done_cnt++;
      if (bus.busy && int'(bus.row_addr) > max_row) max_row = int'(bus.row_addr);
      if (stalled) begin
        chk("stall_valid", 32'(bus.hit_valid), 32'd1);
        chk("stall_hold", 32'({bus.hit_row, bus.hit_col}), 32'(held));
      end
      if (bus.hit_valid) begin
        if (bus.hit_ready) begin
          if (exp_q.size() == 0) chk("unexpected_hit", 32'({bus.hit_row, bus.hit_col}), 32'hFFFF);
          else chk("hit_rowcol", 32'({bus.hit_row, bus.hit_col}), 32'(exp_q.pop_front()));
        end
        stalled = !bus.hit_ready;
        held = {bus.hit_row, bus.hit_col};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // reference: every slot equal to a nonzero target, rows in order, cols ascending
  task automatic build_exp(input int n, input logic [LITW-1:0] tgt, output int cnt);
    int rows;
    rows = (n > NROWS) ? NROWS : n;
    cnt = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < COLS; c++)
        if (tgt != 0 && tbl[r][c] == tgt) begin
          exp_q.push_back({ROW_W'(r), COL_W'(c)});
          cnt++;
        end
  endtask

  task automatic pulse_start(input int n, input logic [LITW-1:0] tgt);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.target_in = tgt;
    bus.num_rows_in = 7'(n);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_scan(input int n, input logic [LITW-1:0] tgt, input int mode, input bit poke);
    int rows, exp_cnt, cyc;
    bit got;
    rows = (n > NROWS) ? NROWS : n;
    build_exp(n, tgt, exp_cnt);
    ready_mode = mode;
    done_cnt = 0;
    max_row = 0;
    pulse_start(n, tgt);
    cyc = 0;
    got = 0;
    while (cyc < BUDGET) begin
      @(negedge clk);
      if (cyc == 0 && rows > 0) chk("busy_after_start", 32'(bus.busy), 32'd1);
      if (bus.done) begin
        got = 1;
        break;
      end
      if (poke && cyc == 4) begin
        pulse_start(1, tgt ^ 6'h15);
        @(negedge clk);
        chk("target_held", 32'(bus.target_literal), 32'(tgt));
      end
      cyc++;
    end
    chk("done_seen", 32'(got), 32'd1);
    if (rows == 0) chk("zero_done_latency", 32'(cyc), 32'd0);
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("busy_low", 32'(bus.busy), 32'd0);
    chk("hit_count", 32'(bus.hit_count), 32'(exp_cnt));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    if (rows > 0) chk("max_row", 32'(max_row), 32'(rows - 1));
    exp_q.delete();
  endtask

  task automatic clear_tbl();
    for (int r = 0; r < NROWS; r++)
      for (int c = 0; c < COLS; c++) tbl[r][c] = '0;
  endtask

  task automatic load_demo();
    clear_tbl();
    tbl[0][0] = 6'd5; tbl[0][1] = 6'd0; tbl[0][2] = 6'd5; tbl[0][3] = 6'd3;
    tbl[2][0] = 6'd7; tbl[2][1] = 6'd5; tbl[2][2] = 6'd5; tbl[2][3] = 6'd5;
  endtask

  task automatic chk_all_zero();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_row_addr", 32'(bus.row_addr), 0);
    chk("rst_target", 32'(bus.target_literal), 0);
    chk("rst_hit_valid", 32'(bus.hit_valid), 0);
    chk("rst_hit_row", 32'(bus.hit_row), 0);
    chk("rst_hit_col", 32'(bus.hit_col), 0);
    chk("rst_hit_count", 32'(bus.hit_count), 0);
    chk("rst_state", 32'(dbg_state), 0);
  endtask

  initial begin
    int cyc, k;
    bus.start = 1'b0;
    bus.target_in = '0;
    bus.num_rows_in = '0;
    clear_tbl();
    repeat (2) @(negedge clk);
    chk_all_zero();
    rst_n = 1'b1;

    // demo table, ready high then random
    load_demo();
    run_scan(3, 6'd5, 0, 0);
    run_scan(3, 6'd5, 1, 0);
    // empty scan and literal-0 target
    run_scan(0, 6'd5, 0, 0);
    run_scan(3, 6'd0, 0, 0);

    // oversize row count clamps to table depth
    clear_tbl();
    for (int r = 0; r < NROWS; r++) tbl[r][0] = 6'd9;
    run_scan(NROWS + 5, 6'd9, 0, 0);

    // start while busy is ignored
    run_scan(NROWS, 6'd9, 1, 1);

    // reset mid-EMIT during a stall, then rescan from row 0
    load_demo();
    build_exp(3, 6'd5, k);
    ready_mode = 0;
    pulse_start(3, 6'd5);
    cyc = 0;
    while (cyc < BUDGET && bus.hit_count < 2) begin
      @(negedge clk);
      cyc++;
    end
    ready_mode = 2;
    while (cyc < BUDGET && !(bus.hit_valid && !bus.hit_ready)) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_reached", 32'(cyc < BUDGET), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_scan(3, 6'd5, 0, 0);

    // randomized scans
    for (int t = 0; t < 10; t++) begin
      for (int r = 0; r < NROWS; r++)
        for (int c = 0; c < COLS; c++) tbl[r][c] = LITW'($urandom_range(0, 7));
      run_scan(int'($urandom_range(0, NROWS + 5)), LITW'($urandom_range(0, 7)),
               int'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
